// File: rtl/inst_decode_stage.sv
// inst_decode_stage
// Decodes raw instruction words into execute-stage control fields and
// buffers the decoded entries in a small FIFO. Producer and consumer each
// have their own handshake, so fetch and execute can stall independently.
// A flush discards everything buffered, e.g. after a taken jump.
module inst_decode_stage #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 2,
  parameter bit STRICT = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_inst,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_ci,
  output logic                         out_sm,
  output logic [5:0]                   out_opc,
  output logic [2:0]                   out_dst,
  output logic [2:0]                   out_j,
  output logic [WIDTH-1:0]             out_w,
  output logic                         out_illegal,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One decoded instruction as held in the FIFO.
  typedef struct packed {
    logic             illegal;
    logic             ci;
    logic             sm;
    logic [5:0]       opc;
    logic [2:0]       dst;
    logic [2:0]       j;
    logic [WIDTH-1:0] w;
  } entry_t;

  entry_t          mem_reg [DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;

  entry_t          dec_next;
  entry_t          head;
  logic [WIDTH-15:0] reserved;
  logic            push;
  logic            pop;

  // Pointers wrap explicitly so DEPTH does not have to be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign reserved = in_inst[WIDTH-2:13];

  // Combinational decode of the incoming word; illegal words become a NOP.
  always_comb begin
    dec_next = '0;
    if (!in_inst[WIDTH-1]) begin
      dec_next.dst = 3'b100;
      dec_next.w   = {1'b0, in_inst[WIDTH-2:0]};
    end else if (STRICT && (reserved != '0)) begin
      dec_next.ci      = 1'b1;
      dec_next.illegal = 1'b1;
    end else begin
      dec_next.ci  = 1'b1;
      dec_next.sm  = in_inst[12];
      dec_next.opc = in_inst[11:6];
      dec_next.dst = in_inst[5:3];
      dec_next.j   = in_inst[2:0];
    end
  end

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign in_ready  = (count_reg < CW'(DEPTH)) || out_ready;
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // FIFO state: reset clears storage too so the head reads as all zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= dec_next;
        wr_ptr_reg          <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head        = mem_reg[rd_ptr_reg];
  assign out_ci      = head.ci;
  assign out_sm      = head.sm;
  assign out_opc     = head.opc;
  assign out_dst     = head.dst;
  assign out_j       = head.j;
  assign out_w       = head.w;
  assign out_illegal = head.illegal;
  assign count       = count_reg;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Bench for inst_decode_stage: two instances (16-bit/depth 2/strict and
// 24-bit/depth 3/non-strict) driven with directed and random traffic, with a
// negedge monitor comparing the head against a queue-based reference.
module tb_inst_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=16, DEPTH=2, STRICT=1
  logic        a_rst, a_flush, a_iv, a_ir, a_ov, a_or;
  logic [15:0] a_inst, a_w;
  logic        a_ci, a_sm, a_ill;
  logic [5:0]  a_opc;
  logic [2:0]  a_dst, a_j;
  logic [1:0]  a_cnt;

  // Instance B: WIDTH=24, DEPTH=3, STRICT=0
  logic        b_rst, b_flush, b_iv, b_ir, b_ov, b_or;
  logic [23:0] b_inst, b_w;
  logic        b_ci, b_sm, b_ill;
  logic [5:0]  b_opc;
  logic [2:0]  b_dst, b_j;
  logic [1:0]  b_cnt;

  inst_decode_stage #(.WIDTH(16), .DEPTH(2), .STRICT(1'b1)) dut_a (
    .clk(clk), .rst(a_rst), .flush(a_flush), .in_valid(a_iv), .in_ready(a_ir),
    .in_inst(a_inst), .out_valid(a_ov), .out_ready(a_or), .out_ci(a_ci),
    .out_sm(a_sm), .out_opc(a_opc), .out_dst(a_dst), .out_j(a_j), .out_w(a_w),
    .out_illegal(a_ill), .count(a_cnt)
  );

  inst_decode_stage #(.WIDTH(24), .DEPTH(3), .STRICT(1'b0)) dut_b (
    .clk(clk), .rst(b_rst), .flush(b_flush), .in_valid(b_iv), .in_ready(b_ir),
    .in_inst(b_inst), .out_valid(b_ov), .out_ready(b_or), .out_ci(b_ci),
    .out_sm(b_sm), .out_opc(b_opc), .out_dst(b_dst), .out_j(b_j), .out_w(b_w),
    .out_illegal(b_ill), .count(b_cnt)
  );

  typedef struct packed {
    logic        ci;
    logic        sm;
    logic [5:0]  opc;
    logic [2:0]  dst;
    logic [2:0]  j;
    logic        ill;
    logic [31:0] w;
  } ent_t;

  int   checks = 0;
  int   errors = 0;
  ent_t q0[$];
  ent_t q1[$];
  bit   started [2];
  bit   rst_pend [2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference decode from the field rules, using shifts and masks on a word
  // of the given width.
  function automatic ent_t ref_decode(input logic [31:0] x, input int wd, input bit strict);
    ent_t        e;
    logic [31:0] kind;
    logic [31:0] rsv;
    e    = '0;
    kind = (x >> (wd - 1)) & 32'd1;
    rsv  = (x >> 13) & ((32'd1 << (wd - 14)) - 32'd1);
    if (kind == 32'd0) begin
      e.dst = 3'd4;
      e.w   = x & ((32'd1 << (wd - 1)) - 32'd1);
    end else if (strict && rsv != 32'd0) begin
      e.ci  = 1'b1;
      e.ill = 1'b1;
    end else begin
      e.ci  = 1'b1;
      e.sm  = 1'(x >> 12);
      e.opc = 6'((x >> 6) & 32'h3F);
      e.dst = 3'((x >> 3) & 32'h7);
      e.j   = 3'(x & 32'h7);
    end
    return e;
  endfunction

  // Monitor for one instance: check visible state against the model, then
  // advance the model by this cycle's handshake.
  task automatic mon(input int s, input int depth, input int wd, input bit strict,
                     input logic r, input logic fl, input logic iv, input logic ir,
                     input logic [31:0] inst, input logic ov, input logic ordy,
                     input logic ci, input logic sm, input logic [5:0] opc,
                     input logic [2:0] dst, input logic [2:0] j, input logic [31:0] w,
                     input logic ill, input logic [1:0] cnt);
    string p;
    ent_t  e;
    int    sz;
    bit    exp_ir;
    p = (s == 0) ? "A" : "B";
    if (!started[s]) begin
      if (r) begin
        started[s]  = 1'b1;
        rst_pend[s] = 1'b1;
      end
      return;
    end
    if (rst_pend[s]) begin
      chk({p, " reset_ctrl"}, 32'({ov, ci, sm, opc, dst, j, ill, cnt}), 32'd0);
      chk({p, " reset_w"}, w, 32'd0);
    end
    sz = (s == 0) ? q0.size() : q1.size();
    chk({p, " count"}, 32'(cnt), 32'(sz));
    chk({p, " out_valid"}, 32'(ov), 32'(sz != 0));
    exp_ir = (sz < depth) || ordy;
    chk({p, " in_ready"}, 32'(ir), 32'(exp_ir));
    if (sz != 0) begin
      e = (s == 0) ? q0[0] : q1[0];
      chk({p, " head_ctrl"}, 32'({ci, sm, opc, dst, j, ill}),
          32'({e.ci, e.sm, e.opc, e.dst, e.j, e.ill}));
      chk({p, " head_w"}, w, e.w);
    end
    rst_pend[s] = r;
    if (r || fl) begin
      if (s == 0) q0.delete(); else q1.delete();
    end else begin
      if (ordy && sz != 0) begin
        if (s == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
      if (iv && exp_ir) begin
        e = ref_decode(inst, wd, strict);
        if (s == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, 2, 16, 1'b1, a_rst, a_flush, a_iv, a_ir, {16'd0, a_inst}, a_ov, a_or,
        a_ci, a_sm, a_opc, a_dst, a_j, {16'd0, a_w}, a_ill, a_cnt);
    mon(1, 3, 24, 1'b0, b_rst, b_flush, b_iv, b_ir, {8'd0, b_inst}, b_ov, b_or,
        b_ci, b_sm, b_opc, b_dst, b_j, {8'd0, b_w}, b_ill, b_cnt);
  end

  task automatic da(input bit r, input bit fl, input bit iv, input logic [15:0] inst, input bit ordy);
    @(posedge clk);
    #1;
    a_rst = r; a_flush = fl; a_iv = iv; a_inst = inst; a_or = ordy;
  endtask

  task automatic db(input bit r, input bit fl, input bit iv, input logic [23:0] inst, input bit ordy);
    @(posedge clk);
    #1;
    b_rst = r; b_flush = fl; b_iv = iv; b_inst = inst; b_or = ordy;
  endtask

  task automatic drive_a();
    da(1, 0, 0, 16'h0, 0);
    da(0, 0, 0, 16'h0, 0);
    // data word
    da(0, 0, 1, 16'h0005, 0);
    da(0, 0, 0, 16'h0, 0);
    @(negedge clk);
    chk("A data_ctrl", 32'({a_ov, a_ci, a_dst, a_opc, a_j, a_ill, a_cnt}),
        32'({1'b1, 1'b0, 3'b100, 6'd0, 3'd0, 1'b0, 2'd1}));
    chk("A data_w", 32'(a_w), 32'h0005);
    da(0, 0, 0, 16'h0, 1);
    // compute word, all fields set
    da(0, 0, 1, 16'h9FFF, 1);
    da(0, 0, 0, 16'h0, 0);
    @(negedge clk);
    chk("A compute_ctrl", 32'({a_ci, a_sm, a_opc, a_dst, a_j, a_ill}),
        32'({1'b1, 1'b1, 6'h3F, 3'b111, 3'b111, 1'b0}));
    chk("A compute_w", 32'(a_w), 32'h0);
    // reserved bits set under strict decode
    da(0, 0, 1, 16'hE0C8, 1);
    da(0, 0, 0, 16'h0, 0);
    @(negedge clk);
    chk("A illegal_ctrl", 32'({a_ci, a_sm, a_opc, a_dst, a_j, a_ill}),
        32'({1'b1, 1'b0, 6'd0, 3'd0, 3'd0, 1'b1}));
    chk("A illegal_w", 32'(a_w), 32'h0);
    da(0, 0, 0, 16'h0, 1);
    // fill to full, third word refused
    da(0, 0, 1, 16'h0011, 0);
    da(0, 0, 1, 16'h0022, 0);
    da(0, 0, 1, 16'h0033, 0);
    @(negedge clk);
    chk("A full_ready", 32'({a_ir, a_cnt}), 32'({1'b0, 2'd2}));
    // push and pop together while full
    da(0, 0, 1, 16'h0033, 1);
    @(negedge clk);
    chk("A full_pushpop_ready", 32'(a_ir), 32'd1);
    chk("A full_pushpop_head", 32'(a_w), 32'h0011);
    da(0, 0, 0, 16'h0, 0);
    @(negedge clk);
    chk("A after_pushpop", 32'({a_cnt, a_w}), 32'({2'd2, 16'h0022}));
    // flush with a word offered in the same cycle
    da(0, 1, 1, 16'h0BEE, 0);
    da(0, 0, 0, 16'h0, 0);
    @(negedge clk);
    chk("A flush_empty", 32'({a_cnt, a_ov}), 32'd0);
    da(0, 0, 1, 16'h1234, 0);
    da(0, 0, 0, 16'h0, 1);
    @(negedge clk);
    chk("A after_flush", 32'({a_ov, a_w}), 32'({1'b1, 16'h1234}));
    // random traffic
    for (int i = 0; i < 300; i++) begin
      da(($urandom % 60) == 0, ($urandom % 20) == 0, 1'($urandom), 16'($urandom),
         ($urandom % 3) != 0);
    end
    repeat (3) da(0, 0, 0, 16'h0, 1);
  endtask

  task automatic drive_b();
    int acc;
    int cyc;
    bit did_rst;
    db(1, 0, 0, 24'h0, 0);
    db(0, 0, 0, 24'h0, 0);
    // reserved bits are ignored when not strict
    db(0, 0, 1, 24'hE000C8, 0);
    db(0, 0, 0, 24'h0, 1);
    @(negedge clk);
    chk("B nonstrict_ctrl", 32'({b_ci, b_ill, b_opc, b_dst, b_j}),
        32'({1'b1, 1'b0, 6'h03, 3'b001, 3'b000}));
    acc = 0;
    cyc = 0;
    did_rst = 1'b0;
    while (acc < 100 && cyc < 3000) begin
      if (acc == 50 && !did_rst) begin
        did_rst = 1'b1;
        db(1, 0, 1, 24'h000777, 1);
        db(0, 0, 0, 24'h0, 0);
        @(negedge clk);
        chk("B midreset", 32'({b_cnt, b_ov, b_ci, b_ill}), 32'd0);
        chk("B midreset_w", 32'(b_w), 32'd0);
      end
      db(0, 0, 1'($urandom), 24'($urandom), 1'($urandom));
      #1;
      if (b_iv && b_ir) acc++;
      cyc++;
    end
    chk("B stream_done", 32'(acc >= 100), 32'd1);
    repeat (4) db(0, 0, 0, 24'h0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b1; a_flush = 1'b0; a_iv = 1'b0; a_inst = '0; a_or = 1'b0;
    b_rst = 1'b1; b_flush = 1'b0; b_iv = 1'b0; b_inst = '0; b_or = 1'b0;
    fork
      drive_a();
      drive_b();
    join
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_decode_stage.md
# inst_decode_stage

Parametrised, registered successor to the combinational instruction decoder. It accepts raw instruction words over a valid/ready handshake and decodes each one into control fields (ci, sm, opc, dst, j, w) plus an illegal flag. Decoded entries are held in a DEPTH-entry FIFO so fetch and execute can stall independently. A flush input discards all buffered entries on a taken jump. It sits between instruction fetch and the ALU/register-file execute stage.

## Interface
- WIDTH, 16, instruction and immediate width; legal range ≥16.
- DEPTH, 2, decoded-entry FIFO depth; legal range ≥1.
- STRICT, 1, 1 = flag compute instructions with nonzero reserved bits as illegal; 0 = ignore reserved bits.
- clk  in  1  clock; one clock domain.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all buffered entries and any word accepted this cycle.
- in_valid  in  1  in_inst is valid.
- in_ready  out  1  stage can accept a word this cycle.
- in_inst  in  WIDTH  raw instruction word.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  consumer takes the head entry this cycle.
- out_ci  out  1  1 = compute instruction, 0 = data (immediate) instruction.
- out_sm  out  1  ALU source select (A vs *A).
- out_opc  out  6  ALU operation flags.
- out_dst  out  3  destination flags {A, D, *A}.
- out_j  out  3  jump condition flags {lt, eq, gt}.
- out_w  out  WIDTH  immediate value.
- out_illegal  out  1  head entry is an illegal instruction.
- count  out  $clog2(DEPTH+1)  number of buffered entries.

## Operation
- Field map: kind = in_inst[WIDTH-1]; sm = in_inst[12]; opc = in_inst[11:6]; dst = in_inst[5:3]; j = in_inst[2:0]; reserved = in_inst[WIDTH-2:13].
- Data instruction (kind=0): ci=0, sm=0, opc=6'b000000, dst=3'b100, j=3'b000, w = {1'b0, in_inst[WIDTH-2:0]}, illegal=0.
- Compute instruction (kind=1): ci=1, w=0, sm/opc/dst/j taken from the field map; illegal = STRICT && (reserved != 0).
- Illegal entry: ci=1, sm=0, opc=0, dst=0, j=0, w=0, illegal=1. This makes it a NOP for execute. The entry is still enqueued and delivered in order.
- Decode is combinational on in_inst. The full decoded entry is written into the FIFO on push. Outputs are driven from the FIFO head and never combinationally from in_inst.
- push = in_valid && in_ready && !flush; pop = out_valid && out_ready && !flush.
- in_ready = (count < DEPTH) || out_ready. This is a combinational path from out_ready: a push is allowed when full if a pop happens the same cycle.
- out_valid = (count != 0).
- Simultaneous push and pop: count is unchanged, pointers both advance. This also holds when full (DEPTH entries) and when count=1 (the new entry becomes head next cycle).
- Pointers wrap modulo DEPTH. DEPTH need not be a power of two.
- flush: next cycle count=0 and pointers are reset. An in_valid word presented in the flush cycle is dropped, although in_ready still reads as computed; the producer treats it as consumed. Flush takes priority over push and pop.
- Head fields are don't-care while out_valid=0.

## Timing
- Reset (rst=1 at a clk edge): count=0, pointers=0, out_valid=0, out_illegal=0, out_ci=0, out_sm=0, out_opc=0, out_dst=0, out_j=0, out_w=0. in_ready=1 once out of reset.
- rst mid-operation behaves as flush plus clearing the head registers. rst has priority over flush.
- Latency: a word pushed in cycle N is presented at the head with out_valid=1 in cycle N+1 if the FIFO was empty.
- Throughput: one instruction per cycle sustained while out_ready=1, for any DEPTH ≥1.
- Handshake: out_* fields stay stable while out_valid=1 and out_ready=0. in_inst is sampled only on push.
- No combinational path from in_* to out_*. The only in/out combinational path is out_ready → in_ready.

## Test plan
- Reset, then push 16'h0005 → next cycle out_valid=1, ci=0, dst=3'b100, opc=0, j=0, w=16'h0005, illegal=0, count=1.
- Push 16'h9FFF (kind=1, reserved=0, WIDTH=16) → ci=1, sm=1, opc=6'h3F, dst=3'b111, j=3'b111, w=0, illegal=0.
- STRICT=1, push 16'hE0C8 (reserved bits 14:13=2'b11) → illegal=1, opc=0, dst=0, j=0, w=0. With STRICT=0, the same word gives illegal=0, opc=6'h03, dst=3'b001.
- DEPTH=2, hold out_ready=0 and push 3 words → count=2, in_ready=0 on the third. Then raise out_ready with in_valid=1 → push and pop in the same cycle, count stays 2, output order preserved.
- With count=2, assert flush with in_valid=1 → next cycle count=0, out_valid=0, the flush-cycle word never appears. Then push 16'h1234 → w=16'h1234 after 1 cycle.
- WIDTH=24, DEPTH=3, stream 100 random words with random out_ready → outputs match a reference decode in order, with no loss or duplication. Assert rst mid-stream → all outputs 0 and count=0 the next cycle.
